seizure_event_responder: RTL and testbench

//  Consumer end of the seizure detector output. Debounces the per-sample seizure decision and

---
 rtl/seizure_event_responder_pkg.sv | 49 ++++
 rtl/seizure_event_responder_if.sv | 28 ++
 rtl/seizure_event_responder_uart_tx_byte.sv | 71 +++++++
 rtl/seizure_event_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_seizure_event_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seizure_event_responder_pkg.sv
// rtl/seizure_event_responder_pkg.sv - shared constants, state codes and event record for the seizure event responder
//
// Purpose: event type codes, UART frame constants, debounce and TX-sequencer state
//          encodings, the queued event record, and the frame byte selector.
// Ports:   none (package).

package seizure_event_responder_pkg;

    localparam logic [7:0] EVT_ONSET  = 8'h01;
    localparam logic [7:0] EVT_OFFSET = 8'h02;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         FRAME_LEN  = 7;

    // Debounce FSM encodings
    localparam logic [1:0] D_IDLE   = 2'd0;
    localparam logic [1:0] D_ONSET  = 2'd1;
    localparam logic [1:0] D_ACTIVE = 2'd2;
    localparam logic [1:0] D_OFFSET = 2'd3;

    // Frame sequencer encodings:
    //   T_START issues the sync byte of a frame started from idle,
    //   T_DATA covers bytes 0..5, T_STOP covers the checksum byte.
    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    typedef struct packed {
        logic [7:0]  evt_type;
        logic [31:0] ts;
    } evt_t;

    // Byte idx of the 7-byte frame for event e; the last byte is the XOR checksum
    // of the type and the four timestamp bytes (the sync byte is excluded).
    function automatic logic [7:0] frame_byte(input evt_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = e.evt_type;
            3'd2:    b = e.ts[31:24];
            3'd3:    b = e.ts[23:16];
            3'd4:    b = e.ts[15:8];
            3'd5:    b = e.ts[7:0];
            default: b = e.evt_type ^ e.ts[31:24] ^ e.ts[23:16] ^ e.ts[15:8] ^ e.ts[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/seizure_event_responder_if.sv
// rtl/seizure_event_responder_if.sv - detector-side and host-side signal bundle of the seizure event responder
//
// Purpose: groups the decision input strobe and the status/UART outputs.
// Signals: en (active-low enable), dec_valid, seizure_in      : master -> slave
//          seizure_state, stim_trig, tx, tx_busy, event_dropped : slave -> master

interface seizure_event_responder_if;

    logic en;
    logic dec_valid;
    logic seizure_in;
    logic seizure_state;
    logic stim_trig;
    logic tx;
    logic tx_busy;
    logic event_dropped;

    modport master (
        output en, dec_valid, seizure_in,
        input  seizure_state, stim_trig, tx, tx_busy, event_dropped
    );

    modport slave (
        input  en, dec_valid, seizure_in,
        output seizure_state, stim_trig, tx, tx_busy, event_dropped
    );

endinterface

// File: rtl/seizure_event_responder_uart_tx_byte.sv
// rtl/seizure_event_responder_uart_tx_byte.sv - 8N1 UART byte serialiser
//
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit,
//          each bit BAUD_DIV clocks long.
// Ports:   clk, rst (async, active low)
//          i_start  load i_data and begin a byte (accepted when idle or on o_done)
//          i_data   byte to send
//          o_tx     serial line, idle high
//          o_done   high in the last cycle of the stop bit

module uart_tx_byte #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          r_tx;
    logic          w_bit_end;
    logic          w_done;

    assign w_bit_end = r_busy && (r_baud == BW'(BAUD_DIV - 1));
    assign w_done    = w_bit_end && (r_bit == 4'd9);

    // Accepting a new start on the done cycle lets bytes run back-to-back
    // with the next start bit immediately following the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= 9'd0;
        end else if (i_start && (!r_busy || w_done)) begin
            r_tx    <= 1'b0;
            r_shift <= {1'b1, i_data};
            r_bit   <= 4'd0;
            r_baud  <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_tx   <= 1'b1;
                end else begin
                    // r_shift[8] is the stop bit, shifted out after the data bits
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_done = w_done;

endmodule

// File: rtl/seizure_event_responder.sv
// rtl/seizure_event_responder.sv - debounce, timestamp, stimulation trigger and UART event reporting
//
// Purpose: debounces per-sample seizure decisions, timestamps confirmed onset/offset
//          events, pulses stim_trig on onset (with refractory hold-off), queues events
//          in a 2-entry FIFO and sends each as a 7-byte 8N1 frame.
// Ports:   clk, rst (async, active low)
//          bus.slave: en (active low), dec_valid, seizure_in in;
//                     seizure_state, stim_trig, tx, tx_busy, event_dropped out

module seizure_event_responder
    import seizure_event_responder_pkg::*;
#(
    parameter int ONSET_CNT   = 4,
    parameter int OFFSET_CNT  = 8,
    parameter int REFRACT_CYC = 1000,
    parameter int TS_WIDTH    = 32,
    parameter int BAUD_DIV    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    seizure_event_responder_if.slave    bus
);

    localparam int CNT_MAX = (ONSET_CNT > OFFSET_CNT) ? ONSET_CNT : OFFSET_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(REFRACT_CYC + 2);

    // ---------------------------------------------------------------- debounce
    logic [1:0]          r_d_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [TS_WIDTH-1:0] r_ts;
    logic [RW-1:0]       r_refract;
    logic                r_seizure;
    logic                r_stim;

    logic [1:0]          w_d_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_adv;
    logic                w_conf_on;
    logic                w_conf_off;

    assign w_adv     = bus.dec_valid & ~bus.en;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_d_next   = r_d_state;
        w_cnt_next = r_cnt;
        w_conf_on  = 1'b0;
        w_conf_off = 1'b0;
        if (w_adv) begin
            case (r_d_state)
                D_IDLE: begin
                    if (bus.seizure_in) begin
                        if (ONSET_CNT == 1) begin
                            w_conf_on = 1'b1;
                            w_d_next  = D_ACTIVE;
                        end else begin
                            w_d_next   = D_ONSET;
                            w_cnt_next = CNT_W'(1);
                        end
                    end
                end
                D_ONSET: begin
                    if (bus.seizure_in) begin
                        if (w_cnt_inc == CNT_W'(ONSET_CNT)) begin
                            w_conf_on  = 1'b1;
                            w_d_next   = D_ACTIVE;
                            w_cnt_next = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_d_next   = D_IDLE;
                        w_cnt_next = '0;
                    end
                end
                D_ACTIVE: begin
                    if (!bus.seizure_in) begin
                        if (OFFSET_CNT == 1) begin
                            w_conf_off = 1'b1;
                            w_d_next   = D_IDLE;
                        end else begin
                            w_d_next   = D_OFFSET;
                            w_cnt_next = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (!bus.seizure_in) begin
                        if (w_cnt_inc == CNT_W'(OFFSET_CNT)) begin
                            w_conf_off = 1'b1;
                            w_d_next   = D_IDLE;
                            w_cnt_next = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_d_next   = D_ACTIVE;
                        w_cnt_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_state <= D_IDLE;
            r_cnt     <= '0;
            r_ts      <= '0;
            r_refract <= '0;
            r_seizure <= 1'b0;
            r_stim    <= 1'b0;
        end else begin
            r_d_state <= w_d_next;
            r_cnt     <= w_cnt_next;
            r_stim    <= 1'b0;
            if (w_adv) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_conf_on) begin
                r_seizure <= 1'b1;
            end else if (w_conf_off) begin
                r_seizure <= 1'b0;
            end
            // Onset while the hold-off is running is still reported, but not stimulated.
            if (w_conf_on && (r_refract == '0)) begin
                r_stim    <= 1'b1;
                r_refract <= RW'(REFRACT_CYC);
            end else if (!bus.en && (r_refract != '0)) begin
                r_refract <= r_refract - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- event FIFO
    evt_t       r_q [2];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_count;
    logic       r_dropped;

    evt_t       w_push_evt;
    evt_t       w_head;
    logic       w_push;
    logic       w_push_ok;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;

    assign w_push              = w_conf_on | w_conf_off;
    assign w_push_evt.evt_type = w_conf_on ? EVT_ONSET : EVT_OFFSET;
    assign w_push_evt.ts       = r_ts;   // pre-increment value of the confirming decision
    assign w_empty             = (r_count == 2'd0);
    assign w_full              = (r_count == 2'd2);
    assign w_push_ok           = w_push & (~w_full | w_pop);
    assign w_head              = r_q[r_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q[0]    <= '0;
            r_q[1]    <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_count   <= 2'd0;
            r_dropped <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_q[r_wr] <= w_push_evt;
                r_wr      <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------- frame sequencer
    logic [1:0] r_t_state;
    logic [2:0] r_byte_idx;
    evt_t       r_frame;

    logic [1:0] w_t_next;
    logic [2:0] w_idx_next;
    logic [2:0] w_start_idx;
    logic       w_start;
    logic       w_latch;
    logic       w_done;
    logic [7:0] w_tx_data;
    logic       w_uart_tx;

    always_comb begin
        w_t_next    = r_t_state;
        w_idx_next  = r_byte_idx;
        w_start_idx = 3'd0;
        w_start     = 1'b0;
        w_latch     = 1'b0;
        w_pop       = 1'b0;
        case (r_t_state)
            T_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_latch  = 1'b1;
                    w_t_next = T_START;
                end
            end
            T_START: begin
                w_start    = 1'b1;
                w_idx_next = 3'd0;
                w_t_next   = T_DATA;
            end
            T_DATA: begin
                if (w_done) begin
                    w_start     = 1'b1;
                    w_start_idx = r_byte_idx + 3'd1;
                    w_idx_next  = r_byte_idx + 3'd1;
                    if (r_byte_idx + 3'd1 == 3'(FRAME_LEN - 1)) begin
                        w_t_next = T_STOP;
                    end
                end
            end
            default: begin
                if (w_done) begin
                    if (!w_empty) begin
                        // Chain straight into the next frame: byte 0 is the
                        // constant sync byte, so the new frame can latch this cycle.
                        w_pop      = 1'b1;
                        w_latch    = 1'b1;
                        w_start    = 1'b1;
                        w_idx_next = 3'd0;
                        w_t_next   = T_DATA;
                    end else begin
                        w_t_next = T_IDLE;
                    end
                end
            end
        endcase
    end

    assign w_tx_data = frame_byte(r_frame, w_start_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t_state  <= T_IDLE;
            r_byte_idx <= 3'd0;
            r_frame    <= '0;
        end else begin
            r_t_state  <= w_t_next;
            r_byte_idx <= w_idx_next;
            if (w_latch) begin
                r_frame <= w_head;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_tx_data),
        .o_tx    (w_uart_tx),
        .o_done  (w_done)
    );

    assign bus.seizure_state = r_seizure;
    assign bus.stim_trig     = r_stim;
    assign bus.tx            = w_uart_tx;
    assign bus.tx_busy       = (r_t_state != T_IDLE) | ~w_empty;
    assign bus.event_dropped = r_dropped;

endmodule

// File: tb/tb_seizure_event_responder.sv
// tb/tb_seizure_event_responder.sv - directed self-checking bench for seizure_event_responder

module tb_seizure_event_responder;

    localparam int BAUD = 16;

    logic clk;
    logic rst;
    seizure_event_responder_if bus();

    seizure_event_responder #(
        .ONSET_CNT   (4),
        .OFFSET_CNT  (8),
        .REFRACT_CYC (1000),
        .TS_WIDTH    (32),
        .BAUD_DIV    (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec;
    int         n_err;
    int         n_stim;
    logic [7:0] rx_q[$];
    logic       w_tx;

    assign w_tx = bus.tx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.stim_trig === 1'b1) n_stim <= n_stim + 1;
    end

    // UART receiver: samples mid-bit on falling clock edges
    initial begin : uart_mon
        logic [7:0] b;
        forever begin
            @(negedge w_tx);
            repeat (BAUD / 2) @(negedge clk);
            if (w_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = w_tx;
                end
                repeat (BAUD) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic dec(input logic v);
        @(negedge clk);
        bus.dec_valid  = 1'b1;
        bus.seizure_in = v;
        @(negedge clk);
        bus.dec_valid  = 1'b0;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] typ, input logic [31:0] ts);
        logic [7:0] exp_b [7];
        logic [7:0] got;
        int         waited;
        exp_b[0] = 8'hA5;
        exp_b[1] = typ;
        exp_b[2] = ts[31:24];
        exp_b[3] = ts[23:16];
        exp_b[4] = ts[15:8];
        exp_b[5] = ts[7:0];
        exp_b[6] = typ ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
        waited = 0;
        while (rx_q.size() < 7 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (rx_q.size() < 7) begin
            n_vec++;
            n_err++;
            $display("FAIL %s frame timeout: got %0d bytes, need 7", name, rx_q.size());
            rx_q.delete();
            return;
        end
        for (int i = 0; i < 7; i++) begin
            got = rx_q.pop_front();
            n_vec++;
            if (got !== exp_b[i]) begin
                n_err++;
                $display("FAIL %s byte%0d: got %02h, need %02h", name, i, got, exp_b[i]);
            end
        end
    endtask

    task automatic test_reset();
        int waited;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.dec_valid = 1'b0;
        bus.seizure_in = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped} !== 5'b00100) begin
            n_err++;
            $display("FAIL reset_hold outputs: got %05b, need 00100",
                     {bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped});
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped} !== 5'b00100) begin
            n_err++;
            $display("FAIL reset_release outputs: got %05b, need 00100",
                     {bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped});
        end
        // Start a frame, then reset while the line is low
        repeat (4) dec(1'b1);
        repeat (300) @(negedge clk);
        n_vec++;
        if (bus.tx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL midframe tx_busy: got %b, need 1", bus.tx_busy);
        end
        waited = 0;
        while (w_tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (w_tx !== 1'b0) begin
            n_err++;
            $display("FAIL midframe low bit: tx got %b, need 0 within 200 cycles", w_tx);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.tx, bus.tx_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL async reset tx/tx_busy: got %02b, need 10", {bus.tx, bus.tx_busy});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped} !== 5'b00100) begin
            n_err++;
            $display("FAIL post_reset outputs: got %05b, need 00100",
                     {bus.seizure_state, bus.stim_trig, bus.tx, bus.tx_busy, bus.event_dropped});
        end
        repeat (250) @(negedge clk);
        rx_q.delete();
    endtask

    task automatic test_glitch();
        int s;
        s = n_stim;
        dec(1'b1); dec(1'b1); dec(1'b1); dec(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_stim != s) begin
            n_err++;
            $display("FAIL glitch stim count: got %0d, need %0d", n_stim, s);
        end
        n_vec++;
        if ({bus.seizure_state, bus.tx, bus.tx_busy} !== 3'b010) begin
            n_err++;
            $display("FAIL glitch state/tx/busy: got %03b, need 010",
                     {bus.seizure_state, bus.tx, bus.tx_busy});
        end
    endtask

    task automatic test_onset();
        repeat (9) dec(1'b0);           // ts 4..12
        repeat (3) dec(1'b1);           // ts 13..15
        dec(1'b1);                      // ts 16 confirms
        n_vec++;
        if ({bus.stim_trig, bus.seizure_state} !== 2'b11) begin
            n_err++;
            $display("FAIL onset stim/state: got %02b, need 11", {bus.stim_trig, bus.seizure_state});
        end
        @(negedge clk);
        n_vec++;
        if (bus.stim_trig !== 1'b0) begin
            n_err++;
            $display("FAIL onset stim width: got %b one cycle later, need 0", bus.stim_trig);
        end
        expect_frame("onset_10", 8'h01, 32'h0000_0010);
    endtask

    task automatic test_refractory();
        int s;
        repeat (8) dec(1'b0);           // ts 17..24
        n_vec++;
        if (bus.seizure_state !== 1'b0) begin
            n_err++;
            $display("FAIL offset state: got %b, need 0", bus.seizure_state);
        end
        expect_frame("off_18", 8'h02, 32'h18);
        s = n_stim;
        repeat (4) dec(1'b1);           // ts 25..28, refractory expired
        n_vec++;
        if (bus.stim_trig !== 1'b1) begin
            n_err++;
            $display("FAIL refr first stim: got %b, need 1", bus.stim_trig);
        end
        repeat (8) dec(1'b0);           // ts 29..36
        repeat (4) dec(1'b1);           // ts 37..40, inside refractory
        n_vec++;
        if ({bus.stim_trig, bus.seizure_state} !== 2'b01) begin
            n_err++;
            $display("FAIL refr second stim/state: got %02b, need 01", {bus.stim_trig, bus.seizure_state});
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (n_stim != s + 1) begin
            n_err++;
            $display("FAIL refr stim count: got %0d, need %0d", n_stim, s + 1);
        end
        expect_frame("on_1c", 8'h01, 32'h1C);
        expect_frame("off_24", 8'h02, 32'h24);
        expect_frame("on_28", 8'h01, 32'h28);
        repeat (8) dec(1'b0);           // ts 41..48
        repeat (4) dec(1'b1);           // ts 49..52, refractory long expired
        n_vec++;
        if (bus.stim_trig !== 1'b1) begin
            n_err++;
            $display("FAIL refr third stim: got %b, need 1", bus.stim_trig);
        end
        expect_frame("off_30", 8'h02, 32'h30);
        expect_frame("on_34", 8'h01, 32'h34);
    endtask

    task automatic test_overflow();
        repeat (8) dec(1'b0);           // ts 53..60, goes on air
        repeat (4) dec(1'b1);           // ts 61..64, queued
        repeat (8) dec(1'b0);           // ts 65..72, queued (full)
        n_vec++;
        if (bus.event_dropped !== 1'b0) begin
            n_err++;
            $display("FAIL ovf dropped early: got %b, need 0", bus.event_dropped);
        end
        repeat (4) dec(1'b1);           // ts 73..76, lost
        n_vec++;
        if ({bus.event_dropped, bus.seizure_state} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf dropped/state: got %02b, need 11", {bus.event_dropped, bus.seizure_state});
        end
        expect_frame("off_3c", 8'h02, 32'h3C);
        expect_frame("on_40", 8'h01, 32'h40);
        expect_frame("off_48", 8'h02, 32'h48);
        repeat (1500) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 0 || bus.tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovf extra frame: got %0d bytes busy=%b, need 0 bytes busy=0", rx_q.size(), bus.tx_busy);
        end
        n_vec++;
        if (bus.event_dropped !== 1'b1) begin
            n_err++;
            $display("FAIL ovf dropped sticky: got %b, need 1", bus.event_dropped);
        end
    endtask

    task automatic test_enable_freeze();
        repeat (8) dec(1'b0);           // ts 77..84, goes on air
        dec(1'b1); dec(1'b1);           // ts 85, 86: run of 2
        bus.en = 1'b1;
        dec(1'b0); dec(1'b0); dec(1'b1); // ignored
        n_vec++;
        if (bus.seizure_state !== 1'b0) begin
            n_err++;
            $display("FAIL freeze state: got %b, need 0", bus.seizure_state);
        end
        expect_frame("off_54", 8'h02, 32'h54);
        bus.en = 1'b0;
        dec(1'b1);                      // ts 87: run of 3
        n_vec++;
        if (bus.seizure_state !== 1'b0) begin
            n_err++;
            $display("FAIL resume early confirm: got %b, need 0", bus.seizure_state);
        end
        dec(1'b1);                      // ts 88 confirms
        n_vec++;
        if ({bus.seizure_state, bus.stim_trig} !== 2'b11) begin
            n_err++;
            $display("FAIL resume confirm state/stim: got %02b, need 11", {bus.seizure_state, bus.stim_trig});
        end
        expect_frame("on_58", 8'h01, 32'h58);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_stim = 0;
        test_reset();
        test_glitch();
        test_onset();
        test_refractory();
        test_overflow();
        test_enable_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
